// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared constants and state encodings for the pipeline hazard
//            controller and its multi-cycle stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    localparam logic c_STOP = 1'b1;

    localparam int c_STG_PC  = 0;
    localparam int c_STG_IF  = 1;
    localparam int c_STG_ID  = 2;
    localparam int c_STG_EX  = 3;
    localparam int c_STG_MEM = 4;
    localparam int c_STG_WB  = 5;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mc_stall_counter.sv
// ============================================================================
// Module   : mc_stall_counter
// Brief    : IDLE/BUSY counter that holds the multi-cycle stage for the
//            requested number of cycles and pulses done on the last one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_stall_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_cycles,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mc_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;
    logic             w_idle_start;

    assign w_load       = (i_cycles == '0) ? '0 : (i_cycles - c_ONE);
    assign w_idle_start = (r_state == MC_IDLE) && i_start;

    // The start cycle already counts as one stall cycle, so BUSY is entered
    // with one less than the loaded value remaining.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (i_start && (w_load != '0)) begin
                        r_state <= MC_BUSY;
                        r_cnt   <= w_load - c_ONE;
                    end
                end
                MC_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= MC_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                default: begin
                    r_state <= MC_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == MC_BUSY);
    assign o_done  = !i_abort &&
                     ((w_idle_start && (w_load == '0)) ||
                      ((r_state == MC_BUSY) && (r_cnt == '0)));
    assign o_stall = !i_abort &&
                     ((w_idle_start && (w_load != '0)) || (r_state == MC_BUSY));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Merges stall requests, multi-cycle busy, jumps and traps into
//            per-stage stall/flush vectors and a handshaked PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int JUMP_STAGE = 3,
    parameter int MC_STAGE   = 3,
    parameter int MC_CNT_W   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  mc_start_i,
    input  logic [MC_CNT_W-1:0]   mc_cycles_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                  pc_ready_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  new_pc_valid_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  mc_busy_o,
    output logic                  mc_done_o
);

    localparam int               IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] c_MC_IDX   = IDX_W'(MC_STAGE);
    localparam logic [IDX_W-1:0] c_JUMP_IDX = IDX_W'(JUMP_STAGE);

    logic                  w_mc_busy;
    logic                  w_mc_done;
    logic                  w_mc_stall;
    logic                  w_src_any;
    logic [IDX_W-1:0]      w_src;
    logic [NUM_STAGES-1:0] w_base_stall;
    logic [NUM_STAGES-1:0] w_base_flush;
    logic [NUM_STAGES-1:0] w_jmask;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_jump_ok;
    logic                  w_new_req;
    logic [ADDR_WIDTH-1:0] w_new_addr;
    logic                  w_pend_stall;
    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_addr;

    mc_stall_counter #(
        .CNT_W (MC_CNT_W)
    ) u_mc_stall_counter (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_start  (mc_start_i),
        .i_cycles (mc_cycles_i),
        .i_abort  (trap_i),
        .o_busy   (w_mc_busy),
        .o_done   (w_mc_done),
        .o_stall  (w_mc_stall)
    );

    // The oldest stalling stage decides how far back the hold reaches.
    always_comb begin
        w_src_any = 1'b0;
        w_src     = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stallreq_i[k] == c_STOP) begin
                w_src_any = 1'b1;
                w_src     = IDX_W'(k);
            end
        end
        if (w_mc_stall && (!w_src_any || (w_src < c_MC_IDX))) begin
            w_src_any = 1'b1;
            w_src     = c_MC_IDX;
        end
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_vec
            assign w_base_stall[k] = w_src_any && (w_src >= IDX_W'(k));
            assign w_jmask[k]      = (k < JUMP_STAGE);
            if (k == 0) begin : g_first
                assign w_base_flush[k] = 1'b0;
            end else begin : g_rest
                assign w_base_flush[k] = w_src_any && (w_src == IDX_W'(k - 1));
            end
        end
    endgenerate

    assign w_jump_ok    = jump_enable_i && !trap_i && (!w_src_any || (w_src < c_JUMP_IDX));
    assign w_new_req    = trap_i || w_jump_ok;
    assign w_new_addr   = trap_i ? trap_addr_i : jump_addr_i;
    assign w_pend_stall = r_pend_valid && !pc_ready_i;

    always_comb begin
        w_stall = w_base_stall;
        w_flush = w_base_flush;
        if (trap_i) begin
            w_stall = '0;
            w_flush = '1;
        end else begin
            if (w_jump_ok) begin
                w_stall = w_stall & ~w_jmask;
                w_flush = w_flush | w_jmask;
            end
            if (w_pend_stall) begin
                w_stall[c_STG_PC] = 1'b1;
            end
        end
    end

    // A request presented with pc_ready_i high is consumed on the spot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else if (w_new_req) begin
            r_pend_valid <= !pc_ready_i;
            r_pend_addr  <= w_new_addr;
        end else if (pc_ready_i) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign stall_o        = rst_n_i ? w_stall : '0;
    assign flush_o        = rst_n_i ? w_flush : '0;
    assign new_pc_valid_o = rst_n_i && (r_pend_valid || w_new_req);
    assign new_pc_o       = !rst_n_i ? '0 : (w_new_req ? w_new_addr : r_pend_addr);
    assign mc_busy_o      = rst_n_i && w_mc_busy;
    assign mc_done_o      = rst_n_i && w_mc_done;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl: vector table plus
//            multi-cycle sequences, expectations queued and checked each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    typedef struct {
        logic [5:0]  sr;
        logic        st;
        logic [5:0]  cyc;
        logic        je;
        logic [31:0] ja;
        logic        tr;
        logic [31:0] ta;
        logic        rdy;
        logic [5:0]  e_st;
        logic [5:0]  e_fl;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stallreq;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        trap;
    logic [31:0] trap_addr;
    logic        pc_ready;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic        mc_busy_o;
    logic        mc_done_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;
    vec_t sbq[$];
    vec_t tbl[12];

    pipe_hazard_ctrl #(
        .NUM_STAGES (6),
        .ADDR_WIDTH (32),
        .JUMP_STAGE (3),
        .MC_STAGE   (3),
        .MC_CNT_W   (6)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .stallreq_i     (stallreq),
        .mc_start_i     (mc_start),
        .mc_cycles_i    (mc_cycles),
        .jump_enable_i  (jump_en),
        .jump_addr_i    (jump_addr),
        .trap_i         (trap),
        .trap_addr_i    (trap_addr),
        .pc_ready_i     (pc_ready),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_valid_o (new_pc_valid_o),
        .new_pc_o       (new_pc_o),
        .mc_busy_o      (mc_busy_o),
        .mc_done_o      (mc_done_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [5:0] sr, input logic st, input logic [5:0] cyc,
        input logic je, input logic [31:0] ja, input logic tr, input logic [31:0] ta,
        input logic rdy, input logic [5:0] es, input logic [5:0] ef,
        input logic ev, input logic [31:0] epc, input logic eb, input logic ed);
        vec_t v;
        v.sr = sr; v.st = st; v.cyc = cyc; v.je = je; v.ja = ja;
        v.tr = tr; v.ta = ta; v.rdy = rdy;
        v.e_st = es; v.e_fl = ef; v.e_v = ev; v.e_pc = epc;
        v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, exp);
        end
    endtask

    task automatic check_front();
        vec_t e;
        e = sbq.pop_front();
        cmp("stall_o", 32'(stall_o), 32'(e.e_st));
        cmp("flush_o", 32'(flush_o), 32'(e.e_fl));
        cmp("new_pc_valid_o", 32'(new_pc_valid_o), 32'(e.e_v));
        if (e.e_v || !rst_n) cmp("new_pc_o", new_pc_o, e.e_pc);
        cmp("mc_busy_o", 32'(mc_busy_o), 32'(e.e_busy));
        cmp("mc_done_o", 32'(mc_done_o), 32'(e.e_done));
    endtask

    task automatic drive(input vec_t v);
        stallreq  = v.sr;
        mc_start  = v.st;
        mc_cycles = v.cyc;
        jump_en   = v.je;
        jump_addr = v.ja;
        trap      = v.tr;
        trap_addr = v.ta;
        pc_ready  = v.rdy;
    endtask

    // Called just after a rising edge; checks at the falling edge.
    task automatic step(input vec_t v);
        step_no++;
        drive(v);
        sbq.push_back(v);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(mk(6'b000100, 1'b0, 6'd0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1,
                 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0));

        // table: {inputs, expected} with controller idle and nothing pending
        tbl[0]  = mk(6'b000100, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000111, 6'b001000, 0, 32'h0,   0, 0);
        tbl[1]  = mk(6'b000000, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000000, 6'b000000, 0, 32'h0,   0, 0);
        tbl[2]  = mk(6'b100000, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b111111, 6'b000000, 0, 32'h0,   0, 0);
        tbl[3]  = mk(6'b000001, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000001, 6'b000010, 0, 32'h0,   0, 0);
        tbl[4]  = mk(6'b010100, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b011111, 6'b100000, 0, 32'h0,   0, 0);
        tbl[5]  = mk(6'b000000, 0, 0, 1, 32'h80, 0, 32'h0,   1, 6'b000000, 6'b000111, 1, 32'h80,  0, 0);
        tbl[6]  = mk(6'b010000, 0, 0, 1, 32'h80, 0, 32'h0,   1, 6'b011111, 6'b100000, 0, 32'h0,   0, 0);
        tbl[7]  = mk(6'b000010, 0, 0, 1, 32'h44, 0, 32'h0,   1, 6'b000000, 6'b000111, 1, 32'h44,  0, 0);
        tbl[8]  = mk(6'b001000, 0, 0, 1, 32'h80, 0, 32'h0,   1, 6'b001111, 6'b010000, 0, 32'h0,   0, 0);
        tbl[9]  = mk(6'b000100, 0, 0, 1, 32'h80, 1, 32'h100, 1, 6'b000000, 6'b111111, 1, 32'h100, 0, 0);
        tbl[10] = mk(6'b000000, 1, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000000, 6'b000000, 0, 32'h0,   0, 1);
        tbl[11] = mk(6'b000000, 1, 1, 0, 32'h0,  0, 32'h0,   1, 6'b000000, 6'b000000, 0, 32'h0,   0, 1);

        // reset state with busy inputs: gated to zero
        repeat (2) @(posedge clk);
        sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        check_front();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // multi-cycle op of 4 cycles; a second start while busy is ignored
        step(mk(0, 1, 6'd4, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 0, 0, 0, 0));
        step(mk(0, 0, 6'd0, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 0, 0, 1, 0));
        step(mk(0, 1, 6'd7, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 0, 0, 1, 0));
        step(mk(0, 0, 6'd0, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 0, 0, 1, 1));
        step(mk(0, 0, 6'd0, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 0, 0, 0));

        // jump held while fetch not ready
        step(mk(0, 0, 0, 1, 32'h80, 0, 0, 0, 6'b000000, 6'b000111, 1, 32'h80, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 6'b000001, 6'b000000, 1, 32'h80, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 6'b000001, 6'b000000, 1, 32'h80, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 0, 1, 6'b000000, 6'b000000, 1, 32'h80, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 0, 1, 6'b000000, 6'b000000, 0, 32'h0,  0, 0));

        // pending jump replaced by a trap
        step(mk(0, 0, 0, 1, 32'h80, 0, 32'h0,   0, 6'b000000, 6'b000111, 1, 32'h80,  0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  1, 32'h100, 0, 6'b000000, 6'b111111, 1, 32'h100, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   0, 6'b000001, 6'b000000, 1, 32'h100, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000000, 6'b000000, 1, 32'h100, 0, 0));
        step(mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 6'b000000, 6'b000000, 0, 32'h0,   0, 0));

        // trap while busy with cnt=5 aborts without a done pulse
        step(mk(0, 1, 6'd7, 0, 0, 0, 32'h0,   1, 6'b001111, 6'b010000, 0, 32'h0,   0, 0));
        step(mk(0, 0, 6'd0, 0, 0, 1, 32'h200, 1, 6'b000000, 6'b111111, 1, 32'h200, 1, 0));
        step(mk(0, 0, 6'd0, 0, 0, 0, 32'h0,   1, 6'b000000, 6'b000000, 0, 32'h0,   0, 0));

        // reset mid-busy with a pending redirect
        step(mk(0, 0, 6'd0,  1, 32'h80, 0, 0, 0, 6'b000000, 6'b000111, 1, 32'h80, 0, 0));
        step(mk(0, 1, 6'd10, 0, 32'h0,  0, 0, 0, 6'b001111, 6'b010000, 1, 32'h80, 0, 0));
        step(mk(0, 0, 6'd0,  0, 32'h0,  0, 0, 0, 6'b001111, 6'b010000, 1, 32'h80, 1, 0));
        step_no++;
        drive(mk(6'b000100, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 32'h0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 32'h0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
